// File: rtl/enoc_wormhole_router_if.sv
// enoc_wormhole_router_if: five-port flit/credit bundle between a router and its neighbours
interface enoc_wormhole_router_if #(
  parameter int DATA_WIDTH = 32
);
  logic [0:4][DATA_WIDTH-1:0] i_data;
  logic [0:4][DATA_WIDTH-1:0] o_data;
  logic [0:4]                 i_data_val;
  logic [0:4]                 o_data_val;
  logic [0:4]                 i_credit;
  logic [0:4]                 o_credit;
  logic                       o_err;
  modport master (output i_data, i_data_val, i_credit, input o_data, o_data_val, o_credit, o_err);
  modport slave  (input i_data, i_data_val, i_credit, output o_data, o_data_val, o_credit, o_err);
endinterface

// File: rtl/enoc_wormhole_router.sv
// enoc_wormhole_router: 5-port XY wormhole mesh router with input FIFOs and credit flow control
module enoc_wormhole_router #(
  parameter int X_NODES    = 4,
  parameter int Y_NODES    = 4,
  parameter int X_LOC      = 0,
  parameter int Y_LOC      = 0,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic clk,
  input logic reset,
  enoc_wormhole_router_if.slave bus
);
  localparam int XW = X_NODES > 1 ? $clog2(X_NODES) : 1;
  localparam int YW = Y_NODES > 1 ? $clog2(Y_NODES) : 1;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [XW-1:0] XL   = XW'(X_LOC);
  localparam logic [YW-1:0] YL   = YW'(Y_LOC);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic [DATA_WIDTH-1:0]      mem [5][DEPTH];
  logic [AW-1:0]              rd_ptr [5];
  logic [AW-1:0]              wr_ptr [5];
  logic [CW-1:0]              cnt [5];
  logic [CW-1:0]              credit_cnt [5];
  logic [2:0]                 rr [5];
  logic [2:0]                 lock_in [5];
  logic [2:0]                 sel [5];
  logic [2:0]                 route [5];
  logic [DATA_WIDTH-1:0]      front [5];
  logic [0:4]                 avail, is_head, route_vld, locked, send, deq, wr_ok;
  logic [0:4][DATA_WIDTH-1:0] data_q;
  logic [0:4]                 val_q, credit_q;
  logic                       err_q, err_c;
  function automatic logic [2:0] rr_idx(input logic [2:0] base, input int k);
    return 3'((int'(base) + k) % 5);
  endfunction
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      front[p]   = mem[p][rd_ptr[p]];
      avail[p]   = cnt[p] != '0;
      is_head[p] = front[p][DATA_WIDTH-1];
      route[p]   = front[p][XW-1:0] > XL ? 3'd2 :
                   front[p][XW-1:0] < XL ? 3'd4 :
                   front[p][XW+YW-1:XW] > YL ? 3'd3 :
                   front[p][XW+YW-1:XW] < YL ? 3'd1 : 3'd0;
    end
  end
  // Scanning from the farthest candidate down lets the one nearest the RR pointer win.
  always_comb begin
    logic [2:0] c;
    c     = '0;
    send  = '0;
    deq   = '0;
    wr_ok = '0;
    err_c = 1'b0;
    for (int o = 0; o < 5; o++) begin
      sel[o] = lock_in[o];
      if (locked[o])
        send[o] = avail[lock_in[o]] && credit_cnt[o] != '0;
      else if (credit_cnt[o] != '0)
        for (int k = 4; k >= 0; k--) begin
          c = rr_idx(rr[o], k);
          if (avail[c] && is_head[c] && !route_vld[c] && route[c] == 3'(o)) begin
            send[o] = 1'b1;
            sel[o]  = c;
          end
        end
      if (send[o]) deq[sel[o]] = 1'b1;
      if (bus.i_credit[o] && credit_cnt[o] == FULL && !send[o]) err_c = 1'b1;
    end
    for (int p = 0; p < 5; p++) begin
      if (avail[p] && !is_head[p] && !route_vld[p]) begin
        deq[p] = 1'b1;
        err_c  = 1'b1;
      end
      wr_ok[p] = bus.i_data_val[p] && (cnt[p] != FULL || deq[p]);
      if (bus.i_data_val[p] && !wr_ok[p]) err_c = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 5; p++) begin
        rd_ptr[p]     <= '0;
        wr_ptr[p]     <= '0;
        cnt[p]        <= '0;
        credit_cnt[p] <= FULL;
        rr[p]         <= '0;
        lock_in[p]    <= '0;
      end
      locked    <= '0;
      route_vld <= '0;
      data_q    <= '0;
      val_q     <= '0;
      credit_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (wr_ok[p]) begin
          mem[p][wr_ptr[p]] <= bus.i_data[p];
          wr_ptr[p]         <= wr_ptr[p] == LAST ? '0 : wr_ptr[p] + 1'b1;
        end
        if (deq[p]) rd_ptr[p] <= rd_ptr[p] == LAST ? '0 : rd_ptr[p] + 1'b1;
        cnt[p] <= cnt[p] + CW'(wr_ok[p]) - CW'(deq[p]);
      end
      for (int o = 0; o < 5; o++) begin
        if (send[o]) begin
          data_q[o] <= front[sel[o]];
          if (locked[o] && front[sel[o]][DATA_WIDTH-2]) begin
            locked[o]          <= 1'b0;
            route_vld[sel[o]]  <= 1'b0;
          end
          if (!locked[o]) begin
            rr[o] <= sel[o] == 3'd4 ? 3'd0 : sel[o] + 3'd1;
            if (!front[sel[o]][DATA_WIDTH-2]) begin
              locked[o]         <= 1'b1;
              lock_in[o]        <= sel[o];
              route_vld[sel[o]] <= 1'b1;
            end
          end
        end
        credit_cnt[o] <= send[o] && !bus.i_credit[o] ? credit_cnt[o] - CW'(1) :
                         !send[o] && bus.i_credit[o] && credit_cnt[o] != FULL ? credit_cnt[o] + CW'(1) :
                         credit_cnt[o];
      end
      val_q    <= send;
      credit_q <= deq;
      err_q    <= err_q | err_c;
    end
  end
  assign bus.o_data     = data_q;
  assign bus.o_data_val = val_q;
  assign bus.o_credit   = credit_q;
  assign bus.o_err      = err_q;
endmodule
